// File: rtl/calc_op_responder.sv
// Operand/opcode write responder for the calculator: latches A, B and the opcode,
// runs add/sub in one cycle and mul/div iteratively, then holds the result for reads.
module calc_op_responder #(
  parameter logic [31:0] ADDR_A = 32'd16,
  parameter logic [31:0] ADDR_B = 32'd20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        guardeNumProcessor,
  input  logic        guardeOpProcessor,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  input  logic [1:0]  opIn,
  input  logic        leaResult,
  output logic [31:0] dataOut,
  output logic        resultValid,
  output logic        busy,
  output logic        divZero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  state_t      state_r, state_s;
  logic [31:0] a_r, a_s;
  logic [31:0] b_r, b_s;
  logic [1:0]  op_r, op_s;
  logic        op_loaded_r, op_loaded_s;
  logic [31:0] result_r, result_s;
  logic        result_valid_r, result_valid_s;
  logic        busy_r, busy_s;
  logic        div_zero_r, div_zero_s;
  logic [31:0] data_out_r, data_out_s;
  logic [4:0]  cnt_r, cnt_s;
  // w1: multiplicand (mul) or dividend/quotient shifter (div); w2: multiplier; acc: product or remainder
  logic [31:0] w1_r, w1_s;
  logic [31:0] w2_r, w2_s;
  logic [31:0] acc_r, acc_s;

  logic        a_write_s;
  logic        b_write_s;
  logic        last_iter_s;
  logic [31:0] mul_acc_s;
  logic [32:0] div_shift_s;
  logic        div_ge_s;
  logic [31:0] div_diff_s;
  logic [31:0] div_rem_s;
  logic [31:0] div_quo_s;

  assign a_write_s   = guardeNumProcessor && (address == ADDR_A);
  assign b_write_s   = guardeNumProcessor && (address == ADDR_B);
  assign last_iter_s = (cnt_r == 5'd31);

  // One shift-add step and one restoring-division step, evaluated from the working registers.
  assign mul_acc_s   = acc_r + (w2_r[0] ? w1_r : 32'd0);
  assign div_shift_s = {acc_r, w1_r[31]};
  assign div_ge_s    = (div_shift_s >= {1'b0, b_r});
  assign div_diff_s  = div_shift_s[31:0] - b_r;
  assign div_rem_s   = div_ge_s ? div_diff_s : div_shift_s[31:0];
  assign div_quo_s   = {w1_r[30:0], div_ge_s};

  // Next-state and next-output logic for the protocol FSM and the iterative datapath.
  always_comb begin
    state_s        = state_r;
    a_s            = a_r;
    b_s            = b_r;
    op_s           = op_r;
    op_loaded_s    = op_loaded_r;
    result_s       = result_r;
    result_valid_s = result_valid_r;
    busy_s         = busy_r;
    div_zero_s     = div_zero_r;
    cnt_s          = cnt_r;
    w1_s           = w1_r;
    w2_s           = w2_r;
    acc_s          = acc_r;
    data_out_s     = (leaResult && result_valid_r) ? result_r : 32'd0;

    case (state_r)
      IDLE, DONE: begin
        if (a_write_s) begin
          a_s            = dataIn;
          op_loaded_s    = 1'b0;
          result_valid_s = 1'b0;
          div_zero_s     = 1'b0;
          state_s        = IDLE;
        end else begin
          a_s = a_r;
        end
        // An opcode strobe in the same cycle as an operand write is applied after it.
        if (guardeOpProcessor) begin
          op_s        = opIn;
          op_loaded_s = 1'b1;
        end else begin
          op_s = op_r;
        end
        if (b_write_s) begin
          b_s = dataIn;
          if (guardeOpProcessor || op_loaded_r) begin
            state_s = EXEC;
            busy_s  = 1'b1;
            cnt_s   = 5'd0;
            w1_s    = a_r;
            w2_s    = dataIn;
            acc_s   = 32'd0;
          end else begin
            state_s = state_r;
          end
        end else begin
          b_s = b_r;
        end
      end

      EXEC: begin
        case (op_r)
          OP_ADD, OP_SUB: begin
            result_s       = (op_r == OP_ADD) ? (a_r + b_r) : (a_r - b_r);
            div_zero_s     = 1'b0;
            busy_s         = 1'b0;
            result_valid_s = 1'b1;
            state_s        = DONE;
          end
          OP_MUL: begin
            acc_s = mul_acc_s;
            w1_s  = {w1_r[30:0], 1'b0};
            w2_s  = {1'b0, w2_r[31:1]};
            cnt_s = cnt_r + 5'd1;
            if (last_iter_s) begin
              result_s       = mul_acc_s;
              div_zero_s     = 1'b0;
              busy_s         = 1'b0;
              result_valid_s = 1'b1;
              state_s        = DONE;
            end else begin
              state_s = EXEC;
            end
          end
          OP_DIV: begin
            if (b_r == 32'd0) begin
              result_s       = 32'hFFFF_FFFF;
              div_zero_s     = 1'b1;
              busy_s         = 1'b0;
              result_valid_s = 1'b1;
              state_s        = DONE;
            end else begin
              acc_s = div_rem_s;
              w1_s  = div_quo_s;
              cnt_s = cnt_r + 5'd1;
              if (last_iter_s) begin
                result_s       = div_quo_s;
                div_zero_s     = 1'b0;
                busy_s         = 1'b0;
                result_valid_s = 1'b1;
                state_s        = DONE;
              end else begin
                state_s = EXEC;
              end
            end
          end
          default: begin
            busy_s  = 1'b0;
            state_s = IDLE;
          end
        endcase
      end

      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      a_r            <= 32'd0;
      b_r            <= 32'd0;
      op_r           <= 2'b00;
      op_loaded_r    <= 1'b0;
      result_r       <= 32'd0;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      div_zero_r     <= 1'b0;
      data_out_r     <= 32'd0;
      cnt_r          <= 5'd0;
      w1_r           <= 32'd0;
      w2_r           <= 32'd0;
      acc_r          <= 32'd0;
    end else begin
      state_r        <= state_s;
      a_r            <= a_s;
      b_r            <= b_s;
      op_r           <= op_s;
      op_loaded_r    <= op_loaded_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
      busy_r         <= busy_s;
      div_zero_r     <= div_zero_s;
      data_out_r     <= data_out_s;
      cnt_r          <= cnt_s;
      w1_r           <= w1_s;
      w2_r           <= w2_s;
      acc_r          <= acc_s;
    end
  end

  assign dataOut     = data_out_r;
  assign resultValid = result_valid_r;
  assign busy        = busy_r;
  assign divZero     = div_zero_r;

endmodule

// File: tb/tb_calc_op_responder.sv
// Bench for calc_op_responder: directed test-plan sequences plus random traffic,
// all outputs checked every cycle against a transaction-level model.
module tb_calc_op_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        guardeNumProcessor;
  logic        guardeOpProcessor;
  logic [31:0] address;
  logic [31:0] dataIn;
  logic [1:0]  opIn;
  logic        leaResult;
  logic [31:0] dataOut;
  logic        resultValid;
  logic        busy;
  logic        divZero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  calc_op_responder dut (
    .clk                (clk),
    .rst                (rst),
    .guardeNumProcessor (guardeNumProcessor),
    .guardeOpProcessor  (guardeOpProcessor),
    .address            (address),
    .dataIn             (dataIn),
    .opIn               (opIn),
    .leaResult          (leaResult),
    .dataOut            (dataOut),
    .resultValid        (resultValid),
    .busy               (busy),
    .divZero            (divZero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic        s_rst, s_num, s_opstb, s_lea;
  logic [31:0] s_addr, s_data;
  logic [1:0]  s_op;
  always @(posedge clk) begin
    s_rst   <= rst;
    s_num   <= guardeNumProcessor;
    s_opstb <= guardeOpProcessor;
    s_lea   <= leaResult;
    s_addr  <= address;
    s_data  <= dataIn;
    s_op    <= opIn;
  end

  // Transaction-level model: the result is computed outright with * and /,
  // and only the cycle count until it appears is tracked.
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_result = 32'd0, m_pend = 32'd0, m_dout = 32'd0;
  logic [1:0]  m_op = 2'b00;
  logic        m_loaded = 1'b0, m_valid = 1'b0, m_dz = 1'b0, m_pend_dz = 1'b0, m_busy = 1'b0;
  int          m_left = 0;
  logic [63:0] m_prod;

  task automatic model_step();
    if (s_rst) begin
      m_a = 32'd0; m_b = 32'd0; m_op = 2'b00; m_loaded = 1'b0;
      m_result = 32'd0; m_valid = 1'b0; m_dz = 1'b0; m_dout = 32'd0;
      m_busy = 1'b0; m_left = 0;
    end else begin
      m_dout = (s_lea && m_valid) ? m_result : 32'd0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy   = 1'b0;
          m_valid  = 1'b1;
          m_result = m_pend;
          m_dz     = m_pend_dz;
        end
      end else begin
        if (s_num && s_addr == 32'd16) begin
          m_a = s_data; m_loaded = 1'b0; m_valid = 1'b0; m_dz = 1'b0;
        end
        if (s_opstb) begin
          m_op = s_op; m_loaded = 1'b1;
        end
        if (s_num && s_addr == 32'd20) begin
          m_b = s_data;
          if (m_loaded) begin
            m_busy    = 1'b1;
            m_pend_dz = 1'b0;
            case (m_op)
              2'b00: begin m_pend = m_a + m_b; m_left = 1; end
              2'b01: begin m_pend = m_a - m_b; m_left = 1; end
              2'b10: begin
                m_prod = {32'd0, m_a} * {32'd0, m_b};
                m_pend = m_prod[31:0];
                m_left = 32;
              end
              default: begin
                if (m_b == 32'd0) begin
                  m_pend = 32'hFFFF_FFFF; m_pend_dz = 1'b1; m_left = 1;
                end else begin
                  m_pend = m_a / m_b; m_left = 32;
                end
              end
            endcase
          end
        end
      end
    end
  endtask

  // Compare process: every falling edge, advance the model and check all outputs.
  initial begin
    forever begin
      @(negedge clk);
      model_step();
      chk("dataOut", dataOut, m_dout);
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("resultValid", {31'd0, resultValid}, {31'd0, m_valid});
      chk("divZero", {31'd0, divZero}, {31'd0, m_dz});
    end
  end

  task automatic idle();
    guardeNumProcessor = 1'b0;
    guardeOpProcessor  = 1'b0;
    address            = 32'd0;
    dataIn             = 32'd0;
    opIn               = 2'b00;
  endtask

  task automatic wr_num(input logic [31:0] ad, input logic [31:0] d);
    guardeNumProcessor = 1'b1;
    address            = ad;
    dataIn             = d;
    @(negedge clk);
    idle();
  endtask

  task automatic wr_op(input logic [1:0] op);
    guardeOpProcessor = 1'b1;
    opIn              = op;
    @(negedge clk);
    idle();
  endtask

  // Called right after the starting B write; counts busy cycles, then lets dataOut load.
  task automatic wait_done(input string name, output int bc);
    bc = 0;
    while (busy && bc < 40) begin
      bc++;
      @(negedge clk);
    end
    if (busy) chk({name, "_timeout"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [1:0] op,
                        input logic [31:0] b, output int bc);
    wr_num(32'd16, a);
    wr_op(op);
    wr_num(32'd20, b);
    wait_done(name, bc);
  endtask

  int bc;

  initial begin
    rst       = 1'b1;
    leaResult = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_dataOut", dataOut, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rv", {31'd0, resultValid}, 32'd0);
    leaResult = 1'b1;

    run_op("add", 32'd7, 2'b00, 32'd5, bc);
    chk("add_busy_cycles", bc, 32'd1);
    chk("add_out", dataOut, 32'd12);
    chk("add_dz", {31'd0, divZero}, 32'd0);

    run_op("sub", 32'd3, 2'b01, 32'd5, bc);
    chk("sub_out", dataOut, 32'hFFFF_FFFE);

    run_op("mul", 32'h0001_0001, 2'b10, 32'h0000_FFFF, bc);
    chk("mul_busy_cycles", bc, 32'd32);
    chk("mul_out", dataOut, 32'hFFFF_FFFF);

    run_op("div", 32'd100, 2'b11, 32'd7, bc);
    chk("div_busy_cycles", bc, 32'd32);
    chk("div_out", dataOut, 32'd14);

    run_op("div0", 32'd9, 2'b11, 32'd0, bc);
    chk("div0_busy_cycles", bc, 32'd1);
    chk("div0_out", dataOut, 32'hFFFF_FFFF);
    chk("div0_dz", {31'd0, divZero}, 32'd1);

    // B write with no opcode loaded does not start anything.
    wr_num(32'd16, 32'd50);
    wr_num(32'd20, 32'd3);
    chk("noop_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("noop_rv", {31'd0, resultValid}, 32'd0);

    // Address 24 is ignored; the later B write starts 50+8.
    wr_op(2'b00);
    wr_num(32'd24, 32'd1);
    chk("addr24_busy", {31'd0, busy}, 32'd0);
    wr_num(32'd20, 32'd8);
    wait_done("addr24", bc);
    chk("addr24_out", dataOut, 32'd58);

    // Early read returns 0; an A write during EXEC is ignored.
    wr_num(32'd16, 32'd3);
    wr_op(2'b10);
    wr_num(32'd20, 32'd4);
    chk("early_out", dataOut, 32'd0);
    wr_num(32'd16, 32'd99);
    chk("exec_busy", {31'd0, busy}, 32'd1);
    wait_done("exec_a", bc);
    chk("exec_a_out", dataOut, 32'd12);

    // Reset in the middle of a multiply.
    wr_num(32'd16, 32'd5);
    wr_op(2'b10);
    wr_num(32'd20, 32'd6);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rv", {31'd0, resultValid}, 32'd0);
    chk("midrst_out", dataOut, 32'd0);
    run_op("post_rst_add", 32'd1, 2'b00, 32'd1, bc);
    chk("post_rst_add_out", dataOut, 32'd2);

    // Random traffic, checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      rst                = ($urandom_range(0, 299) == 0);
      guardeNumProcessor = ($urandom_range(0, 3) == 0);
      guardeOpProcessor  = ($urandom_range(0, 4) == 0);
      opIn               = 2'($urandom_range(0, 3));
      leaResult          = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       address = 32'd16;
        1:       address = 32'd20;
        2:       address = 32'd24;
        default: address = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       dataIn = 32'd0;
        1:       dataIn = 32'($urandom_range(0, 255));
        default: dataIn = $urandom;
      endcase
      @(negedge clk);
    end

    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
